// File: rtl/mem_request_unit.sv
// Memory request sequencer: issues instruction/data requests, holds a data request until dhit, pulses pc_en on retire.
// Optional stall watchdog enabled by defining MEM_REQ_WATCHDOG_EN (adds the timeout output).
module mem_request_unit #(
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             cu_iREN,
    input  logic             cu_dREN,
    input  logic             cu_dWEN,
    input  logic             cu_halt,
    input  logic             ihit,
    input  logic             dhit,
    output logic             imemREN,
    output logic             dmemREN,
    output logic             dmemWEN,
    output logic             pc_en,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
`ifdef MEM_REQ_WATCHDOG_EN
    ,
    output logic             timeout
`endif
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DATA   = 2'd1,
        HALTED = 2'd2
    } state_t;

    if (TIMEOUT_CYCLES < 1 || CNT_W < 1) begin : g_bad_param
        $error("mem_request_unit: CNT_W and TIMEOUT_CYCLES must be >= 1");
    end

    state_t           state_q, state_d;
    logic             dren_q, dren_d;
    logic             dwen_q, dwen_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             imem_c, pc_c, hit_c, miss_c;

`ifdef MEM_REQ_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            timeout_q, timeout_d;
`endif

    // State and registered outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= FETCH;
            dren_q    <= 1'b0;
            dwen_q    <= 1'b0;
            halted_q  <= 1'b0;
            stall_q   <= '0;
`ifdef MEM_REQ_WATCHDOG_EN
            wd_q      <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            dren_q    <= dren_d;
            dwen_q    <= dwen_d;
            halted_q  <= halted_d;
            stall_q   <= stall_d;
`ifdef MEM_REQ_WATCHDOG_EN
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    // Next-state, request latching and stall accounting
    always_comb begin
        state_d  = state_q;
        dren_d   = dren_q;
        dwen_d   = dwen_q;
        halted_d = halted_q;
        stall_d  = stall_q;
        imem_c   = 1'b0;
        pc_c     = 1'b0;
        hit_c    = 1'b0;
        miss_c   = 1'b0;

        case (state_q)
            FETCH: begin
                imem_c = cu_iREN;
                if (ihit) begin
                    hit_c = 1'b1;
                    if (cu_halt) begin
                        state_d  = HALTED;
                        halted_d = 1'b1;
                    end else if (cu_dREN || cu_dWEN) begin
                        state_d = DATA;
                        dwen_d  = cu_dWEN;
                        dren_d  = cu_dREN & ~cu_dWEN;
                    end else begin
                        pc_c = 1'b1;
                    end
                end else if (cu_iREN) begin
                    miss_c = 1'b1;
                end
            end
            DATA: begin
                if (dhit) begin
                    hit_c   = 1'b1;
                    pc_c    = 1'b1;
                    state_d = FETCH;
                    dren_d  = 1'b0;
                    dwen_d  = 1'b0;
                end else begin
                    miss_c = 1'b1;
                end
            end
            HALTED: begin
                dren_d   = 1'b0;
                dwen_d   = 1'b0;
                halted_d = 1'b1;
            end
            default: begin
                state_d = FETCH;
                dren_d  = 1'b0;
                dwen_d  = 1'b0;
            end
        endcase

        if (miss_c && stall_q != '1) begin
            stall_d = stall_q + CNT_W'(1);
        end

`ifdef MEM_REQ_WATCHDOG_EN
        wd_d      = wd_q;
        timeout_d = timeout_q;
        if (hit_c) begin
            wd_d = '0;
        end else if (miss_c) begin
            wd_d = wd_q + WD_W'(1);
            // Consecutive misses reached the limit: give up and park in HALTED
            if (wd_d == WD_W'(TIMEOUT_CYCLES)) begin
                state_d   = HALTED;
                halted_d  = 1'b1;
                dren_d    = 1'b0;
                dwen_d    = 1'b0;
                timeout_d = 1'b1;
            end
        end
`endif
    end

    // Combinational outputs are forced low while reset is held
    assign imemREN   = imem_c & ~RST;
    assign pc_en     = pc_c & ~RST;
    assign dmemREN   = dren_q;
    assign dmemWEN   = dwen_q;
    assign halted    = halted_q;
    assign stall_cnt = stall_q;
`ifdef MEM_REQ_WATCHDOG_EN
    assign timeout   = timeout_q;
`endif

endmodule

// File: tb/tb_mem_request_unit.sv
// Directed table-driven bench for mem_request_unit plus hand sequences for reset, saturation and watchdog.
module tb_mem_request_unit;

`ifdef MEM_REQ_WATCHDOG_EN
    localparam int unsigned TO = 8;
`else
    localparam int unsigned TO = 1024;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        cu_iREN = 1'b0, cu_dREN = 1'b0, cu_dWEN = 1'b0, cu_halt = 1'b0;
    logic        ihit = 1'b0, dhit = 1'b0;
    logic        imemREN, dmemREN, dmemWEN, pc_en, halted;
    logic [31:0] stall_cnt;
    logic        s_imemREN, s_dmemREN, s_dmemWEN, s_pc_en, s_halted;
    logic [2:0]  s_stall_cnt;
`ifdef MEM_REQ_WATCHDOG_EN
    logic        timeout, s_timeout;
`endif

    int tests = 0;
    int fails = 0;

    mem_request_unit #(.CNT_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .RST(RST), .cu_iREN(cu_iREN), .cu_dREN(cu_dREN), .cu_dWEN(cu_dWEN),
        .cu_halt(cu_halt), .ihit(ihit), .dhit(dhit), .imemREN(imemREN), .dmemREN(dmemREN),
        .dmemWEN(dmemWEN), .pc_en(pc_en), .halted(halted), .stall_cnt(stall_cnt)
`ifdef MEM_REQ_WATCHDOG_EN
        , .timeout(timeout)
`endif
    );

    // Narrow-counter instance for the saturation check
    mem_request_unit #(.CNT_W(3), .TIMEOUT_CYCLES(TO)) dut_s (
        .CLK(CLK), .RST(RST), .cu_iREN(cu_iREN), .cu_dREN(cu_dREN), .cu_dWEN(cu_dWEN),
        .cu_halt(cu_halt), .ihit(ihit), .dhit(dhit), .imemREN(s_imemREN), .dmemREN(s_dmemREN),
        .dmemWEN(s_dmemWEN), .pc_en(s_pc_en), .halted(s_halted), .stall_cnt(s_stall_cnt)
`ifdef MEM_REQ_WATCHDOG_EN
        , .timeout(s_timeout)
`endif
    );

    always #5 CLK = ~CLK;

    // in  = {RST, cu_iREN, cu_dREN, cu_dWEN, cu_halt, ihit, dhit}
    // out = {imemREN, dmemREN, dmemWEN, pc_en, halted}, observed before the next rising edge
    typedef struct {
        logic [6:0]  in;
        logic [4:0]  out;
        int unsigned stall;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [6:0] v);
        {RST, cu_iREN, cu_dREN, cu_dWEN, cu_halt, ihit, dhit} = v;
    endtask

    initial begin
        // reset, then ihit held with no data op
        vecs[0]  = '{7'b1100000, 5'b00000, 0};
        vecs[1]  = '{7'b0100010, 5'b10010, 0};
        vecs[2]  = '{7'b0100010, 5'b10010, 0};
        vecs[3]  = '{7'b0100010, 5'b10010, 0};
        // data read, dhit after three miss cycles
        vecs[4]  = '{7'b0110010, 5'b10000, 0};
        vecs[5]  = '{7'b0110000, 5'b01000, 0};
        vecs[6]  = '{7'b0110000, 5'b01000, 1};
        vecs[7]  = '{7'b0110000, 5'b01000, 2};
        vecs[8]  = '{7'b0110001, 5'b01010, 3};
        vecs[9]  = '{7'b0100000, 5'b10000, 3};
        // read+write: write wins; dhit ignored in FETCH, ihit/cu_* ignored in DATA
        vecs[10] = '{7'b0111011, 5'b10000, 4};
        vecs[11] = '{7'b0100110, 5'b00100, 4};
        vecs[12] = '{7'b0100001, 5'b00110, 5};
        vecs[13] = '{7'b0100000, 5'b10000, 5};
        // halt beats write; halted is sticky until reset
        vecs[14] = '{7'b0101110, 5'b10000, 6};
        vecs[15] = '{7'b0100011, 5'b00001, 6};
        vecs[16] = '{7'b0100000, 5'b00001, 6};
        vecs[17] = '{7'b1100000, 5'b00000, 0};

        #12;
        for (int i = 0; i < NV; i++) begin
            @(negedge CLK);
            drive(vecs[i].in);
            #1;
            check($sformatf("vec%0d", i),
                  {27'd0, imemREN, dmemREN, dmemWEN, pc_en, halted, stall_cnt},
                  {27'd0, vecs[i].out, vecs[i].stall});
        end

        // Reset asserted mid-DATA drops the request without a clock edge
        @(negedge CLK); drive(7'b0110010);
        @(negedge CLK); drive(7'b0110000);
        @(negedge CLK); #1;
        check("data_before_rst", 64'(dmemREN), 64'd1);
        #2 RST = 1'b1;
        #1;
        check("rst_mid_data_dren", 64'({dmemREN, dmemWEN, imemREN, pc_en}), 64'd0);
        check("rst_mid_data_stall", 64'(stall_cnt), 64'd0);
        @(negedge CLK); drive(7'b0100000);
        #1;
        check("resume_imem_hi", 64'(imemREN), 64'd1);
        cu_iREN = 1'b0;
        #1;
        check("resume_imem_lo", 64'(imemREN), 64'd0);

        // Eight consecutive instruction misses
        @(negedge CLK); RST = 1'b1;
        @(negedge CLK); drive(7'b0100000);
        repeat (8) @(negedge CLK);
        #1;
        check("miss8_stall", 64'(stall_cnt), 64'd8);
        check("miss8_sat_stall", 64'(s_stall_cnt), 64'd7);
`ifdef MEM_REQ_WATCHDOG_EN
        check("wd_timeout", 64'({timeout, halted, imemREN}), 64'b110);
`else
        check("no_wd_waiting", 64'({halted, imemREN, pc_en}), 64'b010);
`endif
        @(negedge CLK); #1;
        check("miss9_sat_stall", 64'(s_stall_cnt), 64'd7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_request_unit.md
Name: mem_request_unit

Overview:
- Consumes the control unit's memory-request outputs: iREN, dREN, dWEN and halt.
- Sequences instruction and data accesses to the memory controller and produces the PC enable for the datapath.
- Sits between the control unit / datapath and the cache/memory controller.
- Holds a data request from the cycle its instruction is fetched until the matching dhit arrives. Latches halt permanently.

Parameters:
- CNT_W, 32, width of the stall cycle counter.
- TIMEOUT_CYCLES, 1024, cycles without a hit before the watchdog fires (used only with the optional feature).

Ports:
- CLK  input  1  system clock, rising-edge
- RST  input  1  asynchronous, active-high reset
- cu_iREN  input  1  instruction read enable from control unit
- cu_dREN  input  1  data read request decoded from the current instruction
- cu_dWEN  input  1  data write request decoded from the current instruction
- cu_halt  input  1  halt decoded from the current instruction
- ihit  input  1  instruction access complete
- dhit  input  1  data access complete
- imemREN  output  1  instruction read request to memory
- dmemREN  output  1  data read request to memory
- dmemWEN  output  1  data write request to memory
- pc_en  output  1  one-cycle pulse: current instruction retired, PC may advance
- halted  output  1  sticky halt indication
- stall_cnt  output  CNT_W  count of cycles spent waiting for a hit

Behaviour:
- Reset values (asynchronous, while RST=1): state=FETCH, imemREN=0, dmemREN=0, dmemWEN=0, pc_en=0, halted=0, stall_cnt=0.
- Timing: all state, dmemREN, dmemWEN, halted and stall_cnt are registered. imemREN and pc_en are combinational from state and inputs.
- FETCH state:
  - imemREN=cu_iREN.
  - On ihit with cu_halt=1: go to HALTED. pc_en=0. Halt has priority over any data request.
  - On ihit with cu_dREN|cu_dWEN: go to DATA. Next cycle dmemWEN=cu_dWEN and dmemREN=cu_dREN&~cu_dWEN; if both are asserted, the write wins. pc_en=0.
  - On ihit with no data op and no halt: pc_en=1 this cycle; stay in FETCH.
  - On no ihit while imemREN=1: stall_cnt+1.
  - dhit is ignored in FETCH.
- DATA state:
  - imemREN=0; dmemREN/dmemWEN are held.
  - On dhit: pc_en=1 this cycle. dmemREN/dmemWEN clear on the next edge; return to FETCH.
  - On no dhit: stall_cnt+1.
  - ihit is ignored in DATA.
  - cu_* inputs are ignored in DATA; the latched request does not change.
- HALTED state:
  - All request outputs are 0, pc_en=0, halted=1.
  - The only exit is RST.
  - stall_cnt freezes.
- stall_cnt saturates at all-ones; it does not wrap.
- A back-to-back hit (ihit in the first FETCH cycle) gives a 0-cycle stall. Minimum instruction latency is 1 cycle without a data op and 2 cycles with one.
- RST asserted mid-DATA drops dmemREN/dmemWEN immediately (asynchronously). The pending request is discarded.
- Control unit contract: cu_* inputs are stable during the ihit cycle.

Optional Feature:
- Macro: MEM_REQ_WATCHDOG_EN.
- When defined:
  - Adds output port timeout (1 bit) and an internal counter of consecutive miss cycles in FETCH or DATA.
  - The counter clears on any accepted hit.
  - When the counter reaches TIMEOUT_CYCLES: timeout=1 (sticky), state goes to HALTED, halted=1, all requests drop on the next edge.
  - RST clears timeout to 0.
- When undefined: no timeout port, no counter; a request waits indefinitely.

Test Plan:
- Reset then ihit=1 held, cu_dREN=cu_dWEN=cu_halt=0 -> pc_en=1 every cycle, dmemREN=0, stall_cnt stays 0.
- ihit pulse with cu_dREN=1, dhit after 3 cycles -> dmemREN=1 for exactly 4 cycles starting the cycle after ihit; imemREN=0 during that time; pc_en pulses once on the dhit cycle; stall_cnt=3.
- ihit with cu_dREN=1 and cu_dWEN=1 -> dmemWEN=1, dmemREN=0; after dhit both are 0 and state returns to FETCH.
- ihit with cu_halt=1 and cu_dWEN=1 -> halted=1 next cycle, dmemWEN never asserts; later ihit/dhit pulses give pc_en=0; RST restores halted=0.
- Assert RST two cycles into DATA (dmemREN=1) -> dmemREN=0 within the same cycle; after release, a fetch resumes with imemREN=cu_iREN.
- With MEM_REQ_WATCHDOG_EN and TIMEOUT_CYCLES=8: hold ihit=0 for 8 cycles -> timeout=1, halted=1, imemREN=0. Without the macro, the same stimulus leaves imemREN=1 and stall_cnt=8.
